// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - parallel request and serial line bundle for uart_tx_ctrl
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmitter: start, LSB-first data, optional parity, one stop bit
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  parity_bit;

  // Parity always comes from the latched word so live input changes cannot leak into a frame
  assign parity_bit = (^data_q) ^ par_typ_q;

  // State, latches and both outputs are flops; the output values are chosen from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, next latched request and the line level to present during the next cycle
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = data_q[0];
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          tx_d      = data_q[bit_cnt_d];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        // A request seen on the stop bit chains straight into the next start bit
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule
